counter_checker: RTL and testbench

//  Self-checking monitor on the output side of the 32-bit 4-mode counter.

---
 rtl/counter_checker.sv | 122 ++++++++++++
 tb/tb_counter_checker.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/counter_checker.sv
// Reference-model monitor for the 32-bit 4-mode counter: compares Q/LOAD (and RCO
// when COUNTER_CHECKER_RCO_EN is defined) one cycle after each stimulus sample.
module counter_checker #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned ERR_CNT_W   = 16,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic                 clk,
    input  logic                 RESET,
    input  logic                 CHK_EN,
    input  logic                 ENABLE,
    input  logic [1:0]           MODO,
    input  logic [WIDTH-1:0]     D,
    input  logic [WIDTH-1:0]     Q_OBS,
    input  logic                 RCO_OBS,
    input  logic [WIDTH/4-1:0]   LOAD_OBS,
    output logic                 ERR,
    output logic [ERR_CNT_W-1:0] ERR_CNT,
    output logic [WIDTH-1:0]     FIRST_EXP,
    output logic [WIDTH-1:0]     FIRST_OBS,
    output logic                 HALTED
);

    localparam int unsigned LW = WIDTH / 4;

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_CHECK = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] exp_q;
    logic             exp_rco;
    logic [LW-1:0]    exp_load;
    logic             mismatch;

    // Reference model: state after the most recent sampled stimulus.
    always_ff @(posedge clk) begin
        if (RESET) begin
            exp_q    <= '0;
            exp_rco  <= 1'b0;
            exp_load <= '0;
        end else if (ENABLE) begin
            exp_load <= '0;
            case (MODO)
                2'b00: begin
                    exp_q   <= exp_q + WIDTH'(1);
                    exp_rco <= (exp_q == '1);
                end
                2'b01: begin
                    exp_q   <= exp_q - WIDTH'(1);
                    exp_rco <= (exp_q == '0);
                end
                2'b10: begin
                    exp_q   <= exp_q - WIDTH'(3);
                    exp_rco <= (exp_q < WIDTH'(3));
                end
                default: begin
                    exp_q    <= D;
                    exp_rco  <= 1'b0;
                    exp_load <= '1;
                end
            endcase
        end else begin
            exp_rco  <= 1'b0;
            exp_load <= '0;
        end
    end

    // Case inequality so that X/Z on an observed bit is reported as a mismatch.
    always_comb begin
        mismatch = (Q_OBS !== exp_q) || (LOAD_OBS !== exp_load);
`ifdef COUNTER_CHECKER_RCO_EN
        if (RCO_OBS !== exp_rco) mismatch = 1'b1;
`endif
    end

`ifndef COUNTER_CHECKER_RCO_EN
    logic unused_rco;
    assign unused_rco = RCO_OBS ^ exp_rco;
`endif

    always_ff @(posedge clk) begin
        if (RESET) begin
            state     <= ST_ARM;
            ERR       <= 1'b0;
            ERR_CNT   <= '0;
            FIRST_EXP <= '0;
            FIRST_OBS <= '0;
            HALTED    <= 1'b0;
        end else begin
            ERR <= 1'b0;
            case (state)
                ST_ARM: begin
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (mismatch && CHK_EN) begin
                        ERR <= 1'b1;
                        if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + ERR_CNT_W'(1);
                        if (ERR_CNT == '0) begin
                            FIRST_EXP <= exp_q;
                            FIRST_OBS <= Q_OBS;
                        end
                        if (STOP_ON_ERR) begin
                            state  <= ST_HALT;
                            HALTED <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    HALTED <= 1'b1;
                end
                default: begin
                    state <= ST_ARM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker: default, 4-bit saturating and stop-on-error instances
// share one stimulus stream.
module tb_counter_checker;

    logic        clk = 1'b0;
    logic        RESET;
    logic        CHK_EN;
    logic        ENABLE;
    logic [1:0]  MODO;
    logic [31:0] D;
    logic [31:0] Q_OBS;
    logic        RCO_OBS;
    logic [7:0]  LOAD_OBS;

    logic        err_a, err_s, err_h;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_s;
    logic [15:0] cnt_h;
    logic [31:0] fexp_a, fobs_a, fexp_s, fobs_s, fexp_h, fobs_h;
    logic        halt_a, halt_s, halt_h;

    int checks = 0;
    int errors = 0;

`ifdef COUNTER_CHECKER_RCO_EN
    localparam logic RCO_ON = 1'b1;
`else
    localparam logic RCO_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    counter_checker #(.WIDTH(32), .ERR_CNT_W(16), .STOP_ON_ERR(1'b0)) dut_a (
        .clk(clk), .RESET(RESET), .CHK_EN(CHK_EN), .ENABLE(ENABLE), .MODO(MODO), .D(D),
        .Q_OBS(Q_OBS), .RCO_OBS(RCO_OBS), .LOAD_OBS(LOAD_OBS),
        .ERR(err_a), .ERR_CNT(cnt_a), .FIRST_EXP(fexp_a), .FIRST_OBS(fobs_a), .HALTED(halt_a)
    );

    counter_checker #(.WIDTH(32), .ERR_CNT_W(4), .STOP_ON_ERR(1'b0)) dut_s (
        .clk(clk), .RESET(RESET), .CHK_EN(CHK_EN), .ENABLE(ENABLE), .MODO(MODO), .D(D),
        .Q_OBS(Q_OBS), .RCO_OBS(RCO_OBS), .LOAD_OBS(LOAD_OBS),
        .ERR(err_s), .ERR_CNT(cnt_s), .FIRST_EXP(fexp_s), .FIRST_OBS(fobs_s), .HALTED(halt_s)
    );

    counter_checker #(.WIDTH(32), .ERR_CNT_W(16), .STOP_ON_ERR(1'b1)) dut_h (
        .clk(clk), .RESET(RESET), .CHK_EN(CHK_EN), .ENABLE(ENABLE), .MODO(MODO), .D(D),
        .Q_OBS(Q_OBS), .RCO_OBS(RCO_OBS), .LOAD_OBS(LOAD_OBS),
        .ERR(err_h), .ERR_CNT(cnt_h), .FIRST_EXP(fexp_h), .FIRST_OBS(fobs_h), .HALTED(halt_h)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stimulus for this edge plus the counter outputs produced by the previous edge.
    task automatic step(input logic en, input logic [1:0] m, input logic [31:0] d,
                        input logic [31:0] q, input logic rco, input logic [7:0] ld);
        ENABLE   = en;
        MODO     = m;
        D        = d;
        Q_OBS    = q;
        RCO_OBS  = rco;
        LOAD_OBS = ld;
        @(posedge clk);
        #1;
    endtask

    initial begin
        RESET = 1'b1; CHK_EN = 1'b1;
        ENABLE = 1'b0; MODO = 2'b00; D = '0; Q_OBS = '0; RCO_OBS = 1'b0; LOAD_OBS = '0;

        step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00);
        step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00);
        chk("rst_err",    {31'b0, err_a},  32'h0);
        chk("rst_cnt",    {16'b0, cnt_a},  32'h0);
        chk("rst_fexp",   fexp_a,          32'h0);
        chk("rst_fobs",   fobs_a,          32'h0);
        chk("rst_halt",   {31'b0, halt_a}, 32'h0);
        chk("rst_halt_h", {31'b0, halt_h}, 32'h0);
        chk("rst_cnt_s",  {28'b0, cnt_s},  32'h0);

        // Load 0xFF then count up three times with a well-behaved counter.
        RESET = 1'b0;
        step(1'b1, 2'b11, 32'h0000_00FF, 32'h0, 1'b0, 8'h00);
        chk("arm_err", {31'b0, err_a}, 32'h0);
        step(1'b1, 2'b00, 32'h0, 32'h0000_00FF, 1'b0, 8'hFF);
        chk("up0_err", {31'b0, err_a}, 32'h0);
        step(1'b1, 2'b00, 32'h0, 32'h0000_0100, 1'b0, 8'h00);
        chk("up1_err", {31'b0, err_a}, 32'h0);
        step(1'b1, 2'b00, 32'h0, 32'h0000_0101, 1'b0, 8'h00);
        chk("up2_err", {31'b0, err_a}, 32'h0);

        // Load 2, down-3 wraps to all-ones with RCO, then two idle cycles hold Q.
        step(1'b1, 2'b11, 32'h0000_0002, 32'h0000_0102, 1'b0, 8'h00);
        chk("up3_err", {31'b0, err_a}, 32'h0);
        chk("up3_cnt", {16'b0, cnt_a}, 32'h0);
        step(1'b1, 2'b10, 32'h0, 32'h0000_0002, 1'b0, 8'hFF);
        chk("ld2_err", {31'b0, err_a}, 32'h0);
        step(1'b0, 2'b00, 32'h0, 32'hFFFF_FFFF, 1'b1, 8'h00);
        chk("dn3_err", {31'b0, err_a}, 32'h0);
        step(1'b0, 2'b00, 32'h0, 32'hFFFF_FFFF, 1'b0, 8'h00);
        chk("hold1_err", {31'b0, err_a}, 32'h0);

        // Load 0x1233, then the counter reports 0x1234 instead.
        step(1'b1, 2'b11, 32'h0000_1233, 32'hFFFF_FFFF, 1'b0, 8'h00);
        chk("hold2_err", {31'b0, err_a}, 32'h0);
        chk("hold2_cnt", {16'b0, cnt_a}, 32'h0);
        step(1'b1, 2'b00, 32'h0, 32'h0000_1234, 1'b0, 8'hFF);
        chk("mm1_err",    {31'b0, err_a},  32'h1);
        chk("mm1_cnt",    {16'b0, cnt_a},  32'h1);
        chk("mm1_fexp",   fexp_a,          32'h0000_1233);
        chk("mm1_fobs",   fobs_a,          32'h0000_1234);
        chk("mm1_halt_h", {31'b0, halt_h}, 32'h1);
        chk("mm1_cnt_h",  {16'b0, cnt_h},  32'h1);
        step(1'b1, 2'b00, 32'h0, 32'h0000_1234, 1'b0, 8'h00);
        chk("ok_err",    {31'b0, err_a}, 32'h0);
        chk("ok_cnt",    {16'b0, cnt_a}, 32'h1);
        chk("ok_err_h",  {31'b0, err_h}, 32'h0);
        step(1'b1, 2'b00, 32'h0, 32'h0000_9999, 1'b0, 8'h00);
        chk("mm2_err",    {31'b0, err_a},  32'h1);
        chk("mm2_cnt",    {16'b0, cnt_a},  32'h2);
        chk("mm2_fexp",   fexp_a,          32'h0000_1233);
        chk("mm2_fobs",   fobs_a,          32'h0000_1234);
        chk("mm2_err_h",  {31'b0, err_h},  32'h0);
        chk("mm2_cnt_h",  {16'b0, cnt_h},  32'h1);
        chk("mm2_fobs_h", fobs_h,          32'h0000_1234);

        // Model now holds 0x1236; twenty wrong Q samples while idle.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 2'b00, 32'h0, 32'h0000_DEAD, 1'b0, 8'h00);
            chk("burst_err", {31'b0, err_a}, 32'h1);
        end
        chk("burst_cnt",    {16'b0, cnt_a},  32'd22);
        chk("burst_cnt_s",  {28'b0, cnt_s},  32'd15);
        chk("burst_cnt_h",  {16'b0, cnt_h},  32'h1);
        chk("burst_halt_h", {31'b0, halt_h}, 32'h1);

        CHK_EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b00, 32'h0, 32'h0000_DEAD, 1'b0, 8'h00);
            chk("dis_err", {31'b0, err_a}, 32'h0);
        end
        chk("dis_cnt",   {16'b0, cnt_a}, 32'd22);
        chk("dis_cnt_s", {28'b0, cnt_s}, 32'd15);

        // Correct Q but a stray LOAD bit.
        CHK_EN = 1'b1;
        step(1'b0, 2'b00, 32'h0, 32'h0000_1236, 1'b0, 8'h01);
        chk("ld_err", {31'b0, err_a}, 32'h1);
        chk("ld_cnt", {16'b0, cnt_a}, 32'd23);
        step(1'b0, 2'b00, 32'h0, 32'h0000_1236, 1'b0, 8'h00);
        chk("ld_ok_err", {31'b0, err_a}, 32'h0);

        // Reset during a mismatching cycle, then the ARM cycle ignores a bad sample.
        RESET = 1'b1;
        step(1'b0, 2'b00, 32'h0, 32'h0000_DEAD, 1'b0, 8'h00);
        chk("rr_err",    {31'b0, err_a},  32'h0);
        chk("rr_cnt",    {16'b0, cnt_a},  32'h0);
        chk("rr_cnt_s",  {28'b0, cnt_s},  32'h0);
        chk("rr_halt_h", {31'b0, halt_h}, 32'h0);
        chk("rr_fexp",   fexp_a,          32'h0);
        RESET = 1'b0;
        step(1'b1, 2'b11, 32'hFFFF_FFFF, 32'h0000_0BAD, 1'b0, 8'h00);
        chk("rarm_err", {31'b0, err_a}, 32'h0);

        // All-ones + 1 wraps with RCO; the counter under test drops RCO.
        step(1'b1, 2'b00, 32'h0, 32'hFFFF_FFFF, 1'b0, 8'hFF);
        chk("wrap_pre_err", {31'b0, err_a}, 32'h0);
        step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00);
        chk("rco_err", {31'b0, err_a}, {31'b0, RCO_ON});
        chk("rco_cnt", {16'b0, cnt_a}, {31'b0, RCO_ON});
        step(1'b1, 2'b00, 32'h0, 32'h0000_0001, 1'b0, 8'h00);
        chk("post_err", {31'b0, err_a}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
